param_fifo: RTL and testbench
=============================

PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter DATA_W, default 8: data word width in bits, minimum 1.
REQ-002 Parameter DEPTH, default 16: number of entries, power of two, minimum 4.
REQ-003 Parameter AF_LEVEL, default DEPTH-2: almost_full threshold, range 1..DEPTH-1.
REQ-004 Parameter AE_LEVEL, default 2: almost_empty threshold, range 1..DEPTH-1.
REQ-005 Parameter MODE, type fifo_mode_e, default MODE_STD: read mode, either MODE_STD (registered read) or MODE_FWFT (first-word-fall-through).
REQ-006 Ports SHALL be as follows; the clock is clk and the reset is rst (asynchronous, active-high).
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- wr_en  in  1  write request.
- din  in  DATA_W  write data.
- rd_en  in  1  read/pop request.
- clr_err  in  1  synchronous clear of the sticky error flags.
- dout  out  DATA_W  read data.
- rd_valid  out  1  dout holds newly read data (MODE_STD only; in MODE_FWFT it is tied to !empty).
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  level >= AF_LEVEL.
- almost_empty  out  1  level <= AE_LEVEL.
- level  out  $clog2(DEPTH)+1  current number of stored entries.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Function
REQ-007 A write SHALL be accepted on a clk edge when wr_en=1 and full=0; din is stored at wr_ptr and wr_ptr increments.
REQ-008 A read SHALL be accepted on a clk edge when rd_en=1 and empty=0; rd_ptr increments.
REQ-009 Pointers SHALL be $clog2(DEPTH)+1 bits wide, with the low bits addressing memory, and SHALL wrap modulo 2*DEPTH without any special case.
REQ-010 level SHALL change as follows: +1 for an accepted write only, -1 for an accepted read only, unchanged when both or neither are accepted.
REQ-011 Simultaneous wr_en and rd_en with 0 < level < DEPTH: both SHALL be accepted, level is unchanged, and FIFO order is preserved.
REQ-012 Simultaneous wr_en and rd_en at full: the read SHALL be accepted, the write rejected, overflow set, and level becomes DEPTH-1.
REQ-013 Simultaneous wr_en and rd_en at empty: the write SHALL be accepted, the read rejected, underflow set, and level becomes 1.
REQ-014 full, empty, almost_full, almost_empty and level SHALL be registered or derived from registered state only, with no combinational path from wr_en or rd_en.
REQ-015 MODE_STD: dout SHALL load the head entry on the edge that accepts a read; rd_valid is 1 for exactly that following cycle; dout holds its value otherwise.
REQ-016 MODE_FWFT: dout SHALL present the head entry whenever empty=0, one cycle after the write to an empty FIFO; rd_en pops the entry and the next entry appears in the following cycle.
REQ-017 overflow and underflow SHALL remain set until clr_err=1 or rst; if clr_err and a new error occur on the same edge, the flag ends set.
REQ-018 All outputs other than dout SHALL be a function of state only.

Reset
REQ-019 rst=1 SHALL immediately set wr_ptr=0, rd_ptr=0, level=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, rd_valid=0 and dout=0.
REQ-020 Reset mid-operation SHALL discard all stored entries; memory contents need not be cleared.
REQ-021 No write or read SHALL be accepted on the edge at which rst is high.

Structure
REQ-022 Package fifo_pkg SHALL hold the typedef fifo_mode_e {MODE_STD, MODE_FWFT} and the default constants FIFO_DEF_DATA_W=8 and FIFO_DEF_DEPTH=16.
REQ-023 Storage SHALL be a separate sub-module fifo_mem: DEPTH x DATA_W, one synchronous write port, and one asynchronous read port.
REQ-024 Parameter legality (power-of-two DEPTH, thresholds in range) SHALL be checked at elaboration with a fatal error.

Verification (DATA_W=8, DEPTH=16, defaults unless noted)
REQ-025 Reset, then write 0x00..0x0F -> almost_full=1 at level 14, full=1 at level 16; a 17th write of 0xFF -> overflow=1, level stays 16.
REQ-026 MODE_STD, 16 reads from full -> dout = 0x00..0x0F, each with rd_valid=1 the cycle after the read; empty=1 after the last read; one more read -> underflow=1, dout holds 0x0F.
REQ-027 At level 5, assert wr_en and rd_en for 10 cycles -> level stays 5 and output order matches input order; at full with both asserted -> level=15, overflow=1.
REQ-028 MODE_FWFT, write 0xA5 into an empty FIFO -> the next cycle empty=0 and dout=0xA5 with no rd_en; rd_en for one cycle -> empty=1.
REQ-029 40 random writes/reads with level kept between 3 and 13 -> pointers wrap at least twice and the scoreboard matches all data.
REQ-030 At level 7 with overflow=1, pulse rst asynchronously mid-cycle -> level=0, empty=1 and overflow=0 before the next clk edge; then write 0x3C and read it -> dout=0x3C.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and defaults for the parameterised FIFO.
package fifo_pkg;

    // Read-side behaviour: registered read or first-word-fall-through.
    typedef enum logic {
        MODE_STD  = 1'b0,
        MODE_FWFT = 1'b1
    } fifo_mode_e;

    localparam int unsigned FIFO_DEF_DATA_W = 8;
    localparam int unsigned FIFO_DEF_DEPTH  = 16;

    // True when v is a non-zero power of two.
    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x DATA_W, one synchronous write port, one asynchronous read port.
module fifo_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Synchronous write; contents are never reset, the pointers define validity.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_fifo.sv
// Synchronous FIFO with level/threshold flags, sticky error flags and a
// selectable registered or first-word-fall-through read side.
module param_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W   = FIFO_DEF_DATA_W,
    parameter int unsigned DEPTH    = FIFO_DEF_DEPTH,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2,
    parameter fifo_mode_e  MODE     = MODE_STD,
    localparam int unsigned AW      = $clog2(DEPTH),
    localparam int unsigned LW      = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    input  logic              clr_err,
    output logic [DATA_W-1:0] dout,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [LW-1:0]     level,
    output logic              overflow,
    output logic              underflow
);

    // Elaboration-time legality checks.
    if (DATA_W < 1) begin : g_bad_data_w
        $fatal(1, "param_fifo: DATA_W must be at least 1");
    end
    if (DEPTH < 4 || !is_pow2(DEPTH)) begin : g_bad_depth
        $fatal(1, "param_fifo: DEPTH must be a power of two and at least 4");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH - 1) begin : g_bad_af
        $fatal(1, "param_fifo: AF_LEVEL must be in 1..DEPTH-1");
    end
    if (AE_LEVEL < 1 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $fatal(1, "param_fifo: AE_LEVEL must be in 1..DEPTH-1");
    end

    localparam logic [LW-1:0] DepthL = LW'(DEPTH);
    localparam logic [LW-1:0] AfL    = LW'(AF_LEVEL);
    localparam logic [LW-1:0] AeL    = LW'(AE_LEVEL);

    // Pointers carry one extra bit and simply wrap modulo 2*DEPTH.
    logic [LW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic              full_s, empty_s;
    logic              wr_acc, rd_acc;
    logic              mem_we;
    logic [DATA_W-1:0] head_data;

    // Status flags come only from the registered level.
    assign full_s  = (level_q == DepthL);
    assign empty_s = (level_q == '0);

    assign full         = full_s;
    assign empty        = empty_s;
    assign almost_full  = (level_q >= AfL);
    assign almost_empty = (level_q <= AeL);
    assign level        = level_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Accept requests only when they can be honoured; a pop at full frees no
    // room for a write on the same edge, and a push at empty has nothing to pop.
    always_comb begin
        wr_acc = wr_en & ~full_s;
        rd_acc = rd_en & ~empty_s;
    end

    // Next-state for pointers, level and sticky error flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({wr_acc, rd_acc})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        // A new error on the clearing edge wins over the clear.
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_en && full_s) begin
            overflow_d = 1'b1;
        end
        if (rd_en && empty_s) begin
            underflow_d = 1'b1;
        end
    end

    // State register with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // No write may land in memory on an edge where reset is asserted.
    assign mem_we = wr_acc & ~rst;

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (din),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (head_data)
    );

    if (MODE == MODE_STD) begin : g_std
        logic [DATA_W-1:0] dout_q;
        logic              rd_valid_q;

        // Registered read: capture the head on the popping edge and flag it for one cycle.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout_q     <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
                if (rd_acc) begin
                    dout_q <= head_data;
                end
            end
        end

        assign dout     = dout_q;
        assign rd_valid = rd_valid_q;
    end else begin : g_fwft
        // Head is always visible; zero while empty so reset shows dout=0.
        assign dout     = empty_s ? '0 : head_data;
        assign rd_valid = ~empty_s;
    end

endmodule

// File: tb/tb_param_fifo.sv
// Directed self-checking bench for param_fifo, one instance per read mode.
module tb_param_fifo;
    import fifo_pkg::*;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] din;
    logic       rd_en;
    logic       clr_err;

    logic [7:0] s_dout, f_dout;
    logic       s_rd_valid, f_rd_valid;
    logic       s_full, f_full, s_empty, f_empty;
    logic       s_af, f_af, s_ae, f_ae;
    logic [4:0] s_level, f_level;
    logic       s_ovf, f_ovf, s_unf, f_unf;

    int total = 0;
    int bad   = 0;

    param_fifo #(.DATA_W(8), .DEPTH(16), .MODE(MODE_STD)) u_std (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .din          (din),
        .rd_en        (rd_en),
        .clr_err      (clr_err),
        .dout         (s_dout),
        .rd_valid     (s_rd_valid),
        .full         (s_full),
        .empty        (s_empty),
        .almost_full  (s_af),
        .almost_empty (s_ae),
        .level        (s_level),
        .overflow     (s_ovf),
        .underflow    (s_unf)
    );

    param_fifo #(.DATA_W(8), .DEPTH(16), .MODE(MODE_FWFT)) u_fwft (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .din          (din),
        .rd_en        (rd_en),
        .clr_err      (clr_err),
        .dout         (f_dout),
        .rd_valid     (f_rd_valid),
        .full         (f_full),
        .empty        (f_empty),
        .almost_full  (f_af),
        .almost_empty (f_ae),
        .level        (f_level),
        .overflow     (f_ovf),
        .underflow    (f_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] exp_v;
        logic       w, r;

        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0; clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_level", 32'(s_level), 0);
        check("rst_empty", 32'(s_empty), 1);
        check("rst_ae", 32'(s_ae), 1);
        check("rst_full", 32'(s_full), 0);
        check("rst_af", 32'(s_af), 0);
        check("rst_ovf", 32'(s_ovf), 0);
        check("rst_unf", 32'(s_unf), 0);
        check("rst_rdv", 32'(s_rd_valid), 0);
        check("rst_dout", 32'(s_dout), 0);
        check("rst_fdout", 32'(f_dout), 0);
        check("rst_frdv", 32'(f_rd_valid), 0);

        // No write accepted on an edge with reset high
        wr_en = 1'b1; din = 8'h99;
        tick();
        check("rst_nowrite", 32'(s_level), 0);
        rst = 1'b0; wr_en = 1'b0;

        // Fill with 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; din = 8'(i);
            tick();
            check("fill_level", 32'(s_level), 32'(i + 1));
            check("fill_af", 32'(s_af), (i + 1 >= 14) ? 1 : 0);
            check("fill_full", 32'(s_full), (i + 1 == 16) ? 1 : 0);
            check("fill_ae", 32'(s_ae), (i + 1 <= 2) ? 1 : 0);
        end
        din = 8'hFF;
        tick();
        wr_en = 1'b0;
        check("ovf_set", 32'(s_ovf), 1);
        check("ovf_level", 32'(s_level), 16);
        check("fwft_head_full", 32'(f_dout), 8'h00);
        check("fwft_rdv_full", 32'(f_rd_valid), 1);

        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("ovf_clr", 32'(s_ovf), 0);

        // Drain 16 entries
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("rd_dout", 32'(s_dout), 32'(i));
            check("rd_rdv", 32'(s_rd_valid), 1);
            check("rd_level", 32'(s_level), 32'(15 - i));
            check("fwft_dout", 32'(f_dout), (i < 15) ? 32'(i + 1) : 0);
        end
        rd_en = 1'b0;
        check("drain_empty", 32'(s_empty), 1);
        check("drain_fempty", 32'(f_empty), 1);
        tick();
        check("rdv_one_cycle", 32'(s_rd_valid), 0);
        check("dout_hold", 32'(s_dout), 8'h0F);

        // Underflow; dout holds
        rd_en = 1'b1;
        tick();
        check("unf_set", 32'(s_unf), 1);
        check("unf_dout", 32'(s_dout), 8'h0F);
        check("unf_rdv", 32'(s_rd_valid), 0);
        check("unf_level", 32'(s_level), 0);

        // Clear on the same edge as a new error: flag stays set
        clr_err = 1'b1;
        tick();
        check("unf_clr_race", 32'(s_unf), 1);
        rd_en = 1'b0;
        tick();
        clr_err = 1'b0;
        check("unf_clr", 32'(s_unf), 0);

        // Simultaneous write and read at empty
        wr_en = 1'b1; rd_en = 1'b1; din = 8'h77;
        tick();
        wr_en = 1'b0;
        check("we_re_empty_level", 32'(s_level), 1);
        check("we_re_empty_unf", 32'(s_unf), 1);
        check("we_re_empty_rdv", 32'(s_rd_valid), 0);
        check("we_re_empty_fdout", 32'(f_dout), 8'h77);
        tick();
        rd_en = 1'b0;
        check("we_re_empty_dout", 32'(s_dout), 8'h77);
        check("we_re_empty_lvl0", 32'(s_level), 0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;

        // Level 5 then 10 cycles of simultaneous write/read
        for (int k = 0; k < 5; k++) begin
            wr_en = 1'b1; din = 8'(8'h10 + k);
            tick();
        end
        check("l5_level", 32'(s_level), 5);
        rd_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            din = 8'(8'h20 + k);
            tick();
            check("l5_dout", 32'(s_dout), (k < 5) ? 32'(8'h10 + k) : 32'(8'h20 + k - 5));
            check("l5_lvl", 32'(s_level), 5);
        end
        rd_en = 1'b0;

        // Fill to full, then write+read at full
        for (int k = 0; k < 11; k++) begin
            din = 8'(8'h30 + k);
            tick();
        end
        check("full2", 32'(s_full), 1);
        rd_en = 1'b1; din = 8'hEE;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check("we_re_full_level", 32'(s_level), 15);
        check("we_re_full_ovf", 32'(s_ovf), 1);
        check("we_re_full_dout", 32'(s_dout), 8'h25);
        check("we_re_full_fdout", 32'(f_dout), 8'h26);

        // Down to level 7 with overflow still set
        rd_en = 1'b1;
        repeat (8) tick();
        rd_en = 1'b0;
        check("l7_level", 32'(s_level), 7);
        check("l7_ovf", 32'(s_ovf), 1);

        // Asynchronous reset mid-cycle takes effect before the next edge
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_level", 32'(s_level), 0);
        check("arst_empty", 32'(s_empty), 1);
        check("arst_ovf", 32'(s_ovf), 0);
        check("arst_rdv", 32'(s_rd_valid), 0);
        check("arst_dout", 32'(s_dout), 0);
        check("arst_flevel", 32'(f_level), 0);
        #1 rst = 1'b0;
        tick();
        wr_en = 1'b1; din = 8'h3C;
        tick();
        wr_en = 1'b0;
        check("post_rst_fdout", 32'(f_dout), 8'h3C);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("post_rst_dout", 32'(s_dout), 8'h3C);
        check("post_rst_rdv", 32'(s_rd_valid), 1);
        check("post_rst_empty", 32'(s_empty), 1);

        // FWFT: head falls through without rd_en
        wr_en = 1'b1; din = 8'hA5;
        tick();
        wr_en = 1'b0;
        check("fwft_empty0", 32'(f_empty), 0);
        check("fwft_a5", 32'(f_dout), 8'hA5);
        check("fwft_rdv", 32'(f_rd_valid), 1);
        tick();
        check("fwft_a5_hold", 32'(f_dout), 8'hA5);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("fwft_pop_empty", 32'(f_empty), 1);
        check("fwft_pop_rdv", 32'(f_rd_valid), 0);

        // Randomised traffic against a queue model, level kept in 3..13
        for (int k = 0; k < 8; k++) begin
            wr_en = 1'b1; din = 8'(8'h40 + k);
            q.push_back(din);
            tick();
        end
        wr_en = 1'b0;
        for (int k = 0; k < 40; k++) begin
            w = (q.size() < 13);
            r = (q.size() > 3) && ($urandom_range(0, 3) != 0);
            wr_en = w; rd_en = r; din = 8'($urandom_range(0, 255));
            exp_v = '0;
            if (r) exp_v = q.pop_front();
            if (w) q.push_back(din);
            tick();
            if (r) check("rnd_dout", 32'(s_dout), 32'(exp_v));
            check("rnd_level", 32'(s_level), 32'(q.size()));
            if (q.size() > 0) check("rnd_fdout", 32'(f_dout), 32'(q[0]));
        end
        wr_en = 1'b0; rd_en = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (q.size() > 0) begin
                rd_en = 1'b1;
                exp_v = q.pop_front();
                tick();
                check("rnd_drain", 32'(s_dout), 32'(exp_v));
            end
        end
        rd_en = 1'b0;
        check("rnd_end_empty", 32'(s_empty), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
